// File: rtl/bsmt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsmt_pkg
// Purpose  : Shared constants and types for the BSMT2000 port-I/O glue.
//            Holds the DSP port numbers, the fetch-engine state encoding and
//            the bit positions of the port-1 status word.
// Revision : 1.0  initial release
// ============================================================================
package bsmt_pkg;

    // DSP I/O port numbers with a fixed meaning
    localparam logic [2:0] PORT_ADDR_LO = 3'd0;  // write: address low word; read: host word
    localparam logic [2:0] PORT_BANK    = 3'd1;  // write: bank; read: status
    localparam logic [2:0] PORT_ROM     = 3'd2;  // read: fetched sample

    // Bit positions inside the port-1 status word
    localparam int STAT_HOST_BUSY  = 0;
    localparam int STAT_FETCH_BUSY = 1;

    // Sample-ROM fetch engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

endpackage : bsmt_pkg
`default_nettype wire

// File: rtl/bsmt_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module   : bsmt_rom_fetch
// Purpose  : Sample-ROM fetch engine. Issues a word read over a toggle
//            req/ack handshake, keeps at most one pending address when a new
//            start arrives while a fetch is in flight, and holds the last
//            accepted sample.
// Ports    : clk, rst            - clock, async active-high reset
//            start, start_addr   - begin a fetch of start_addr
//            rom_addr, rom_req   - address and toggle request to memory
//            rom_ack, rom_data   - toggle acknowledge and returned word
//            sample              - last accepted ROM word
//            busy, valid         - fetch in flight / sample register fresh
// Revision : 1.0  initial release
// ============================================================================
module bsmt_rom_fetch
    import bsmt_pkg::*;
#(
    parameter int ROM_AW = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROM_AW-1:0] start_addr,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [15:0]       rom_data,
    output logic [15:0]       sample,
    output logic              busy,
    output logic              valid
);

    fetch_state_t      state;
    logic              pend;      // newer address waiting behind the in-flight fetch
    logic              reissue;   // stale data was dropped; issue pend_addr this cycle
    logic [ROM_AW-1:0] pend_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= 1'b0;
            reissue   <= 1'b0;
            pend_addr <= '0;
            rom_addr  <= '0;
            rom_req   <= 1'b0;
            sample    <= '0;
        end else begin
            case (state)
                IDLE, VALID: begin
                    if (start) begin
                        rom_addr <= start_addr;
                        rom_req  <= ~rom_req;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (reissue) begin
                        // Handshake is idle (ack==req) here, so it must not be
                        // mistaken for a completion; the newest address wins.
                        rom_addr <= start ? start_addr : pend_addr;
                        rom_req  <= ~rom_req;
                        reissue  <= 1'b0;
                    end else if (rom_ack == rom_req) begin
                        if (pend || start) begin
                            // Returned word belongs to a superseded address.
                            pend      <= 1'b0;
                            reissue   <= 1'b1;
                            pend_addr <= start ? start_addr : pend_addr;
                        end else begin
                            sample <= rom_data;
                            state  <= VALID;
                        end
                    end else if (start) begin
                        pend      <= 1'b1;
                        pend_addr <= start_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == FETCH);
    assign valid = (state == VALID);

endmodule : bsmt_rom_fetch
`default_nettype wire

// File: rtl/bsmt_port_io.sv
`default_nettype none
// ============================================================================
// Module   : bsmt_port_io
// Purpose  : TMS320C1X I/O-bus glue for the BSMT2000 sound core. Decodes DSP
//            port writes into sample-ROM fetches, stalls the DSP on sample
//            reads until data arrives, latches host commands and collects
//            the stereo output pair.
// Ports    : clk, rst                    - clock, async active-high reset
//            ce_r                        - DSP rising-phase enable
//            dsp_a/do/di/we_n/den_n/rdy  - DSP I/O bus
//            host_data/wr/busy           - host command interface
//            rom_addr/req/ack/data       - sample-ROM toggle handshake
//            snd_l, snd_r, snd_stb       - stereo sample output and strobe
// Revision : 1.0  initial release
// ============================================================================
module bsmt_port_io
    import bsmt_pkg::*;
#(
    parameter int         ROM_AW     = 20,
    parameter int         BANK_W     = 4,
    parameter logic [2:0] LEFT_PORT  = 3'd3,
    parameter logic [2:0] RIGHT_PORT = 3'd7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_r,
    input  logic [2:0]        dsp_a,
    input  logic [15:0]       dsp_do,
    output logic [15:0]       dsp_di,
    input  logic              dsp_we_n,
    input  logic              dsp_den_n,
    output logic              dsp_rdy,
    input  logic [15:0]       host_data,
    input  logic              host_wr,
    output logic              host_busy,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [15:0]       rom_data,
    output logic [15:0]       snd_l,
    output logic [15:0]       snd_r,
    output logic              snd_stb
);

    logic              wr_ev;
    logic              rd_ev;
    logic              fetch_start;
    logic [ROM_AW-1:0] fetch_addr;
    logic [BANK_W-1:0] bank;
    logic [15:0]       host_word;
    logic [15:0]       sample;
    logic [15:0]       status;
    logic              fetch_busy;
    logic              fetch_valid;

    assign wr_ev = ce_r & ~dsp_we_n;
    assign rd_ev = ce_r & ~dsp_den_n;

    // The low address word goes straight into the fetch engine, which keeps
    // it in rom_addr or in its pending slot.
    assign fetch_start = wr_ev && (dsp_a == PORT_ADDR_LO);
    assign fetch_addr  = {bank, dsp_do};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank      <= '0;
            snd_l     <= '0;
            snd_r     <= '0;
            snd_stb   <= 1'b0;
            host_word <= '0;
            host_busy <= 1'b0;
        end else begin
            snd_stb <= wr_ev && (dsp_a == RIGHT_PORT);
            if (wr_ev) begin
                if (dsp_a == PORT_BANK)  bank  <= dsp_do[BANK_W-1:0];
                if (dsp_a == LEFT_PORT)  snd_l <= dsp_do;
                if (dsp_a == RIGHT_PORT) snd_r <= dsp_do;
            end
            // A new host word wins over a simultaneous DSP read of the old one.
            if (host_wr) begin
                host_word <= host_data;
                host_busy <= 1'b1;
            end else if (rd_ev && (dsp_a == PORT_ADDR_LO)) begin
                host_busy <= 1'b0;
            end
        end
    end

    bsmt_rom_fetch #(
        .ROM_AW (ROM_AW)
    ) u_fetch (
        .clk        (clk),
        .rst        (rst),
        .start      (fetch_start),
        .start_addr (fetch_addr),
        .rom_addr   (rom_addr),
        .rom_req    (rom_req),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .sample     (sample),
        .busy       (fetch_busy),
        .valid      (fetch_valid)
    );

    always_comb begin
        status                  = '0;
        status[STAT_HOST_BUSY]  = host_busy;
        status[STAT_FETCH_BUSY] = fetch_busy;
    end

    always_comb begin
        dsp_di = '0;
        case (dsp_a)
            PORT_ADDR_LO: dsp_di = host_word;
            PORT_BANK:    dsp_di = status;
            PORT_ROM:     dsp_di = sample;
            default:      dsp_di = '0;
        endcase
    end

    // Stall a sample read only while the fetch is still outstanding.
    assign dsp_rdy = !((dsp_a == PORT_ROM) && !dsp_den_n && fetch_busy);

    // fetch_valid is informational; the stall logic keys off fetch_busy.
    logic unused_ok;
    assign unused_ok = fetch_valid;

endmodule : bsmt_port_io
`default_nettype wire
